// File: rtl/tdc_fine_encoder.sv
// rtl/tdc_fine_encoder.sv - thermometer-to-binary fine encoder with coarse timestamp tagging
// Optional drop counter enabled by defining TDC_ENC_DROP_CNT_EN.
module tdc_fine_encoder #(
    parameter int NUM      = 12,
    parameter int COARSE_W = 16,
    localparam int FINE_W  = $clog2(NUM + 1)
) (
    input  logic                       clk,
    input  logic                       iRst_n,
    input  logic                       iEnable,
    input  logic [NUM-1:0]             iFF,
    input  logic                       iReady,
    output logic                       oValid,
    output logic [COARSE_W+FINE_W-1:0] oTimestamp,
    output logic [COARSE_W-1:0]        oCoarse
`ifdef TDC_ENC_DROP_CNT_EN
    ,
    output logic [15:0]                oDropCnt
`endif
);

    logic [COARSE_W-1:0] rCoarse;
    logic [NUM-1:0]      rThm;
    logic [COARSE_W-1:0] rCrs1;
    logic                rPrevTap0;
    logic                ev1;
    logic [FINE_W-1:0]   thmCount;
    logic [FINE_W-1:0]   rFine;
    logic [COARSE_W-1:0] rCrs2;
    logic                ev2;

    assign oCoarse = rCoarse;

    // Free-running coarse counter, wraps naturally at 2^COARSE_W.
    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            rCoarse <= '0;
        end else begin
            rCoarse <= rCoarse + 1'b1;
        end
    end

    // Stage 1: capture thermometer word and coarse tag; rThm resets to all
    // ones so the first sample after reset cannot look like a rising tap0.
    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            rThm      <= '1;
            rCrs1     <= '0;
            rPrevTap0 <= 1'b1;
        end else begin
            rThm      <= iFF;
            rCrs1     <= rCoarse;
            rPrevTap0 <= rThm[0];
        end
    end

    // A hit is the first sample where tap0 rises; held hits give one event.
    assign ev1 = rThm[0] & ~rPrevTap0 & iEnable;

    // Popcount of the thermometer word; counting ones absorbs bubbles.
    always_comb begin
        thmCount = '0;
        for (int i = 0; i < NUM; i++) begin
            thmCount = thmCount + FINE_W'(rThm[i]);
        end
    end

    // Stage 2: register the fine code and carry the coarse tag along.
    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            rFine <= '0;
            rCrs2 <= '0;
            ev2   <= 1'b0;
        end else begin
            if (ev1) begin
                rFine <= thmCount;
            end
            rCrs2 <= rCrs1;
            ev2   <= ev1;
        end
    end

    // Stage 3: output register with valid/ready; a new event while stalled is dropped.
    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            oValid     <= 1'b0;
            oTimestamp <= '0;
        end else if (ev2 && (!oValid || iReady)) begin
            oTimestamp <= {rCrs2, rFine};
            oValid     <= 1'b1;
        end else if (oValid && iReady) begin
            oValid <= 1'b0;
        end
    end

`ifdef TDC_ENC_DROP_CNT_EN
    logic dropEvent;
    assign dropEvent = ev2 & oValid & ~iReady;

    // Saturating count of events lost to backpressure; cleared only by reset.
    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            oDropCnt <= '0;
        end else if (dropEvent && (oDropCnt != 16'hFFFF)) begin
            oDropCnt <= oDropCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdc_fine_encoder.sv
// tb/tb_tdc_fine_encoder.sv - scoreboard testbench for tdc_fine_encoder
module tb_tdc_fine_encoder;

    localparam int NUM      = 12;
    localparam int COARSE_W = 16;
    localparam int FINE_W   = $clog2(NUM + 1);
    localparam int TS_W     = COARSE_W + FINE_W;

    logic                clk = 1'b0;
    logic                iRst_n;
    logic                iEnable;
    logic [NUM-1:0]      iFF;
    logic                iReady;
    logic                oValid;
    logic [TS_W-1:0]     oTimestamp;
    logic [COARSE_W-1:0] oCoarse;
`ifdef TDC_ENC_DROP_CNT_EN
    logic [15:0]         oDropCnt;
`endif

    int testsRun  = 0;
    int testsFail = 0;
    logic [COARSE_W-1:0] tbCoarse = '0;
    logic [TS_W-1:0]     sb[$];
    logic [TS_W-1:0]     heldTs;

    tdc_fine_encoder #(.NUM(NUM), .COARSE_W(COARSE_W)) dut (
        .clk(clk),
        .iRst_n(iRst_n),
        .iEnable(iEnable),
        .iFF(iFF),
        .iReady(iReady),
        .oValid(oValid),
        .oTimestamp(oTimestamp),
        .oCoarse(oCoarse)
`ifdef TDC_ENC_DROP_CNT_EN
        ,
        .oDropCnt(oDropCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected timestamp for a hit driven now (captured at the next edge).
    task automatic pushHit(input logic [FINE_W-1:0] fine);
        sb.push_back({tbCoarse, fine});
    endtask

    // One clock: update the coarse model, then pop/compare on every new load.
    task automatic tick();
        logic vB, rB, rstB;
        logic [TS_W-1:0] exp;
        vB   = oValid;
        rB   = iReady;
        rstB = iRst_n;
        @(posedge clk);
        if (!rstB) tbCoarse = '0;
        else       tbCoarse = tbCoarse + 1'b1;
        #1;
        if (rstB && oValid && (!vB || rB)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 64'(oTimestamp), 64'h0);
            end else begin
                exp = sb.pop_front();
                check("timestamp", 64'(oTimestamp), 64'(exp));
            end
        end
    endtask

    initial begin
        int guard;
        iRst_n  = 1'b0;
        iEnable = 1'b1;
        iReady  = 1'b1;
        iFF     = 12'hFFF;

        // Reset held for 3 cycles with all taps high
        repeat (3) tick();
        check("reset_valid", 64'(oValid), 64'h0);
        check("reset_coarse", 64'(oCoarse), 64'h0);
`ifdef TDC_ENC_DROP_CNT_EN
        check("reset_dropcnt", 64'(oDropCnt), 64'h0);
`endif
        iRst_n = 1'b1;
        repeat (10) tick();
        check("release_no_event", 64'(oValid), 64'h0);
        check("coarse_count", 64'(oCoarse), 64'd10);

        // Single hit captured at coarse 0x0010
        iFF = 12'h000;
        guard = 0;
        while (tbCoarse != 16'h0010 && guard < 100) begin
            tick();
            guard++;
        end
        check("reach_coarse_16", 64'(tbCoarse), 64'h10);
        iFF = 12'h03F;
        pushHit(4'd6);
        tick();
        iFF = 12'hFFF;
        tick();
        check("latency_t1", 64'(oValid), 64'h0);
        tick();
        check("latency_t2", 64'(oValid), 64'h1);
        check("single_ts", 64'(oTimestamp), 64'({16'h0010, 4'd6}));
        tick();
        check("pulse_one_cycle", 64'(oValid), 64'h0);

        // Bubbled code held high: one event, fine = 6
        iFF = 12'h000;
        repeat (2) tick();
        iFF = 12'b0000_1011_0111;
        pushHit(4'd6);
        repeat (8) tick();
        check("bubble_drained", 64'(sb.size()), 64'h0);

        // Backpressure: first held, second dropped
        iReady = 1'b0;
        iFF = 12'h000;
        tick();
        iFF = 12'h007;
        pushHit(4'd3);
        heldTs = {tbCoarse, 4'd3};
        tick();
        iFF = 12'h000;
        repeat (2) tick();
        check("bp_first_valid", 64'(oValid), 64'h1);
        iFF = 12'h00F;
        tick();
        iFF = 12'h000;
        repeat (4) tick();
        check("bp_valid_held", 64'(oValid), 64'h1);
        check("bp_ts_stable", 64'(oTimestamp), 64'(heldTs));
`ifdef TDC_ENC_DROP_CNT_EN
        check("bp_dropcnt", 64'(oDropCnt), 64'h1);
`endif
        iReady = 1'b1;
        tick();
        check("bp_released", 64'(oValid), 64'h0);

        // Accept and new event in the same cycle
        iReady = 1'b0;
        tick();
        iFF = 12'h003;
        pushHit(4'd2);
        tick();
        iFF = 12'h000;
        tick();
        iFF = 12'h01F;
        pushHit(4'd5);
        tick();
        check("acc_first_valid", 64'(oValid), 64'h1);
        iFF = 12'h000;
        tick();
        iReady = 1'b1;
        tick();
        check("acc_valid_stays", 64'(oValid), 64'h1);
`ifdef TDC_ENC_DROP_CNT_EN
        check("acc_no_drop", 64'(oDropCnt), 64'h1);
`endif
        tick();
        check("acc_drained", 64'(oValid), 64'h0);

        // Hit captured at coarse 0xFFFF
        guard = 0;
        while (tbCoarse != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        check("reach_coarse_ffff", 64'(tbCoarse), 64'hFFFF);
        iFF = 12'h1FF;
        pushHit(4'd9);
        tick();
        iFF = 12'hFFF;
        repeat (2) tick();
        check("wrap_valid", 64'(oValid), 64'h1);
        check("wrap_ts", 64'(oTimestamp), 64'({16'hFFFF, 4'd9}));
        check("wrap_coarse", 64'(oCoarse), 64'h2);

        // Reset one cycle after a hit sample discards it
        iFF = 12'h000;
        repeat (2) tick();
        iFF = 12'h07F;
        tick();
        iRst_n = 1'b0;
        tick();
        iRst_n = 1'b1;
        iFF = 12'hFFF;
        check("midrst_valid", 64'(oValid), 64'h0);
        check("midrst_coarse", 64'(oCoarse), 64'h0);
        repeat (4) tick();
        check("midrst_no_event", 64'(oValid), 64'h0);
        check("midrst_coarse_run", 64'(oCoarse), 64'h4);

        // Enable low suppresses events; enabling with tap0 high gives none
        iEnable = 1'b0;
        iFF = 12'h000;
        tick();
        iFF = 12'h0FF;
        repeat (3) tick();
        check("disabled_no_event", 64'(oValid), 64'h0);
        iEnable = 1'b1;
        repeat (3) tick();
        check("enable_high_tap0", 64'(oValid), 64'h0);
        iFF = 12'h000;
        tick();
        iFF = 12'h001;
        pushHit(4'd1);
        repeat (3) tick();
        check("min_fine_valid", 64'(oValid), 64'h1);
        tick();

        check("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/tdc_fine_encoder.md
Name: tdc_fine_encoder

Overview:
- Downstream consumer of the Fine delay-line stage.
- Takes the NUM-bit registered thermometer word from the Fine second FF column and detects the first cycle a hit appears.
- Converts the thermometer word to a binary fine code with bubble tolerance, and tags it with a free-running coarse counter.
- Presents the resulting timestamp on a valid/ready output toward the readout FIFO.

Parameters:
- NUM, 12, thermometer width (taps); multiple of 4, must match Fine.
- COARSE_W, 16, coarse counter width.
- FINE_W, $clog2(NUM+1), fine code width (derived; not overridden).

Ports:
- clk  input  1  system clock, same clock as Fine.
- iRst_n  input  1  synchronous active-low reset.
- iEnable  input  1  arms event detection; coarse counter runs regardless.
- iFF  input  NUM  thermometer word from Fine; bit 0 = first tap after the CARRY4 CYINIT.
- iReady  input  1  downstream accepts the timestamp when iReady=1 and oValid=1.
- oValid  output  1  timestamp valid.
- oTimestamp  output  COARSE_W+FINE_W  {coarse, fine}.
- oCoarse  output  COARSE_W  live coarse counter, for debug/alignment.
- oDropCnt  output  16  overflow drop counter (exists only with the optional feature).

Behaviour:
- Reset: iRst_n sampled low at a clk edge clears all state on that edge.
  - Pipeline valids, oValid and oTimestamp go to 0.
  - Coarse counter goes to 0; rPrevTap0 goes to 1 (prevents a false event at reset release).
  - oDropCnt goes to 0.
  - Events in flight are discarded. Reset mid-handshake drops the pending timestamp.
- Coarse counter:
  - Increments by 1 every clk outside reset; wraps from 2^COARSE_W-1 to 0.
  - oCoarse is the registered counter value.
- Stage 1 (edge t):
  - rThm <= iFF; rCrs1 <= coarse; rPrevTap0 <= rThm[0].
  - Event flag: ev1 = rThm[0] & ~rPrevTap0 & iEnable, evaluated on the rThm contents.
- Stage 2 (edge t+1):
  - rFine <= popcount(rThm) when ev1, width FINE_W. Popcount absorbs bubbles, so 1011 0111 counts as 6.
  - rCrs2 <= rCrs1; ev2 <= ev1.
  - Fine range is 1..NUM; 0 is impossible because tap0 = 1.
- Stage 3 / output (edge t+2): see the handshake rules below.
- Latency: iFF captured at edge t gives oValid=1 after edge t+2, i.e. 3 registered stages including rThm.
- Throughput: at most one event per rising transition of tap0. A hit held high produces exactly one event. A new event needs tap0 to return to 0 for at least one sample.
- Output handshake:
  - If ev2 and (oValid==0 or iReady==1): oTimestamp <= {rCrs2, rFine}, oValid <= 1.
  - Else if oValid and iReady: oValid <= 0.
  - If ev2 while oValid==1 and iReady==0: the new event is dropped and the old timestamp is held unchanged.
- Simultaneous accept and new event: the new timestamp loads in the same cycle and oValid stays 1.
- Coarse wrap: the coarse value is the one captured at stage 1, so a wrap during the pipeline does not corrupt the tag.
- iEnable low:
  - No events are generated; rPrevTap0 still tracks the input.
  - Asserting iEnable while tap0 is already 1 produces no event.
- oTimestamp is stable while oValid=1 and iReady=0.

Optional Feature:
- Macro: TDC_ENC_DROP_CNT_EN.
- Defined:
  - oDropCnt port exists.
  - Increments on every dropped event (ev2 & oValid & ~iReady) and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined:
  - oDropCnt port and counter are absent; drops are silent.
  - All other behaviour is identical.

Test Plan (NUM=12, COARSE_W=16, feature enabled unless noted):
- Reset: hold iRst_n=0 for 3 cycles with iFF=12'hFFF.
  - Required: oValid=0, oCoarse=0, oDropCnt=0.
  - After release with iFF held at 12'hFFF: no event is ever produced.
- Single hit, iReady=1: iFF goes 12'h000 -> 12'h03F at the edge where coarse=0x0010, then 12'hFFF.
  - Required: oValid pulses 1 cycle after 2 further edges.
  - Required: oTimestamp={16'h0010, 4'd6}.
- Bubble: iFF=12'b0000_1011_0111 after 12'h000, iReady=1.
  - Required: fine=4'd6, exactly one event.
- Backpressure: iReady=0; two hits separated by 12'h000 samples.
  - Required: first timestamp is held stable and the second is dropped; oDropCnt=1.
  - After iReady=1 for one cycle: oValid=0.
- Accept plus new event in the same cycle: iReady=1 on the cycle ev2 asserts while oValid=1.
  - Required: oValid stays 1 and oTimestamp updates to the new value; no drop counted.
- Coarse wrap and mid-operation reset:
  - Hit captured at coarse=0xFFFF: tag is 0xFFFF with the correct fine value.
  - iRst_n=0 one cycle after a hit sample: no oValid, and oCoarse restarts at 0.
  - With the macro undefined: the backpressure case compiles with no oDropCnt port.
